a2_bridge_responder: RTL and testbench

Target-side endpoint of the Apple II bus bridge. Decodes the 3-bit select / rd_n / wr_n / 8-bit data port driven by the FPGA bus master and answers with synchronized snapshots of the Apple II address, data, R/W and control lines. It accepts writes that drive the Apple data bus and the INH/IRQ open-drain lines. It sits between the Apple slot pins and the bridge port, replacing the discrete bridge on boards with direct slot I/O, and serves as the bus model in master-side benches.

---
 rtl/a2_bridge_pkg.sv | 26 ++
 rtl/a2_bridge_sync.sv | 21 ++
 rtl/a2_bridge_responder.sv | 85 ++++++++
 tb/tb_a2_bridge_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/a2_bridge_pkg.sv
// a2_bridge_pkg: shared select codes, control bit indices and types for the Apple II bridge
package a2_bridge_pkg;
  localparam logic [2:0] SEL_CTRL    = 3'd0;
  localparam logic [2:0] SEL_DATA    = 3'd1;
  localparam logic [2:0] SEL_ADDR_LO = 3'd2;
  localparam logic [2:0] SEL_ADDR_HI = 3'd3;
  localparam logic [2:0] SEL_M2      = 3'd4;
  localparam logic [2:0] SEL_DIP     = 3'd5;
  localparam int CTRL_RW    = 0;
  localparam int CTRL_INH   = 1;
  localparam int CTRL_IRQ   = 2;
  localparam int CTRL_RDY   = 3;
  localparam int CTRL_DMA   = 4;
  localparam int CTRL_NMI   = 5;
  localparam int CTRL_RESET = 6;
  typedef enum logic {SNAP_LIVE, SNAP_HELD} snap_state_t;
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw_n;
    logic        m2sel_n;
    logic        m2b0;
    logic [5:0]  ctrl_n;
    logic [3:0]  dip_n;
  } apple_bus_t;
endpackage

// File: rtl/a2_bridge_sync.sv
// a2_bridge_sync: multi-stage flop synchronizer for a bundle of asynchronous inputs
module a2_bridge_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_stages [STAGES];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) r_stages[i] <= '0;
    end else begin
      r_stages[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_stages[i] <= r_stages[i-1];
    end
  end
  assign o_q = r_stages[STAGES-1];
endmodule

// File: rtl/a2_bridge_responder.sv
// a2_bridge_responder: Apple II slot-side endpoint answering bridge reads from a coherent snapshot and accepting control/data writes
module a2_bridge_responder
  import a2_bridge_pkg::*;
#(
  parameter int         SYNC_STAGES   = 2,
  parameter logic [7:0] CONTROL_RESET = 8'hFF
) (
  input  logic        clk_logic,
  input  logic        reset,
  input  logic [2:0]  bridge_sel_i,
  input  logic        bridge_rd_n_i,
  input  logic        bridge_wr_n_i,
  input  logic        bridge_bus_a_oe_n_i,
  input  logic        bridge_bus_d_oe_n_i,
  input  logic [7:0]  bridge_d_i,
  output logic [7:0]  bridge_d_o,
  output logic        bridge_d_oe_o,
  input  logic [15:0] apple_addr_i,
  input  logic [7:0]  apple_data_i,
  input  logic        apple_rw_n_i,
  input  logic        apple_m2sel_n_i,
  input  logic        apple_m2b0_i,
  input  logic [5:0]  apple_ctrl_n_i,
  input  logic [3:0]  dip_switches_n_i,
  output logic [7:0]  apple_data_o,
  output logic        apple_data_oe_o,
  output logic        apple_inh_n_o,
  output logic        apple_irq_n_o,
  output logic        snapshot_held_o,
  output logic        protocol_error_o
);
  apple_bus_t  w_sync, r_live, r_snap;
  snap_state_t r_state, w_state_nx;
  logic [7:0]  r_control_out, r_data_out;
  logic        r_perr, w_rd, w_wr, w_write, w_freeze;
  a2_bridge_sync #(.WIDTH($bits(apple_bus_t)), .STAGES(SYNC_STAGES)) u_sync (
    .clk (clk_logic),
    .rst (reset),
    .i_d ({apple_addr_i, apple_data_i, apple_rw_n_i, apple_m2sel_n_i, apple_m2b0_i,
           apple_ctrl_n_i, dip_switches_n_i}),
    .o_q (w_sync)
  );
  assign w_rd     = !bridge_rd_n_i;
  assign w_wr     = !bridge_wr_n_i;
  assign w_write  = w_wr && !w_rd;
  assign w_freeze = w_rd && (bridge_sel_i == SEL_DATA || bridge_sel_i == SEL_ADDR_LO);
  always_comb begin
    w_state_nx = r_state == SNAP_LIVE ? (w_freeze ? SNAP_HELD : SNAP_LIVE)
                                      : (w_rd ? SNAP_HELD : SNAP_LIVE);
  end
  always_ff @(posedge clk_logic) begin
    if (reset) begin
      r_state       <= SNAP_LIVE;
      r_live        <= '0;
      r_snap        <= '0;
      r_control_out <= CONTROL_RESET;
      r_data_out    <= '0;
      r_perr        <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_live  <= w_sync;
      if (bridge_bus_a_oe_n_i) r_live.addr <= r_live.addr;
      // the snapshot stops moving at the freezing edge so the whole read burst sees one sample
      if (r_state == SNAP_LIVE && !w_freeze) r_snap <= r_live;
      if (w_write && bridge_sel_i == SEL_CTRL) r_control_out <= bridge_d_i;
      if (w_write && bridge_sel_i == SEL_DATA) r_data_out <= bridge_d_i;
      if (w_rd && w_wr) r_perr <= 1'b1;
    end
  end
  always_comb begin
    bridge_d_o = bridge_sel_i == SEL_CTRL    ? {1'b1, r_snap.ctrl_n, r_snap.rw_n} :
                 bridge_sel_i == SEL_DATA    ? r_snap.data :
                 bridge_sel_i == SEL_ADDR_LO ? r_snap.addr[7:0] :
                 bridge_sel_i == SEL_ADDR_HI ? r_snap.addr[15:8] :
                 bridge_sel_i == SEL_M2      ? {6'b111111, r_snap.m2sel_n, r_snap.m2b0} :
                 bridge_sel_i == SEL_DIP     ? {4'hF, r_snap.dip_n} : 8'hFF;
  end
  assign bridge_d_oe_o    = !reset && w_rd && !w_wr;
  assign apple_inh_n_o    = r_control_out[CTRL_INH];
  assign apple_irq_n_o    = r_control_out[CTRL_IRQ];
  assign apple_data_o     = r_data_out;
  assign apple_data_oe_o  = !bridge_bus_d_oe_n_i;
  assign snapshot_held_o  = r_state == SNAP_HELD;
  assign protocol_error_o = r_perr;
endmodule

// File: tb/tb_a2_bridge_responder.sv
// tb_a2_bridge_responder: directed stimulus with a pin-history reference model and literal spot checks
module tb_a2_bridge_responder;
  localparam int S = 2;
  logic clk_logic = 1'b0;
  always #5 clk_logic = ~clk_logic;
  logic reset, bridge_rd_n_i, bridge_wr_n_i, bridge_bus_a_oe_n_i, bridge_bus_d_oe_n_i;
  logic [2:0] bridge_sel_i;
  logic [7:0] bridge_d_i, bridge_d_o, apple_data_i, apple_data_o;
  logic bridge_d_oe_o, apple_rw_n_i, apple_m2sel_n_i, apple_m2b0_i;
  logic [15:0] apple_addr_i;
  logic [5:0] apple_ctrl_n_i;
  logic [3:0] dip_switches_n_i;
  logic apple_data_oe_o, apple_inh_n_o, apple_irq_n_o, snapshot_held_o, protocol_error_o;
  int total = 0, bad = 0;
  a2_bridge_responder #(.SYNC_STAGES(S), .CONTROL_RESET(8'hFF)) dut (
    .clk_logic(clk_logic), .reset(reset), .bridge_sel_i(bridge_sel_i),
    .bridge_rd_n_i(bridge_rd_n_i), .bridge_wr_n_i(bridge_wr_n_i),
    .bridge_bus_a_oe_n_i(bridge_bus_a_oe_n_i), .bridge_bus_d_oe_n_i(bridge_bus_d_oe_n_i),
    .bridge_d_i(bridge_d_i), .bridge_d_o(bridge_d_o), .bridge_d_oe_o(bridge_d_oe_o),
    .apple_addr_i(apple_addr_i), .apple_data_i(apple_data_i), .apple_rw_n_i(apple_rw_n_i),
    .apple_m2sel_n_i(apple_m2sel_n_i), .apple_m2b0_i(apple_m2b0_i),
    .apple_ctrl_n_i(apple_ctrl_n_i), .dip_switches_n_i(dip_switches_n_i),
    .apple_data_o(apple_data_o), .apple_data_oe_o(apple_data_oe_o),
    .apple_inh_n_o(apple_inh_n_o), .apple_irq_n_o(apple_irq_n_o),
    .snapshot_held_o(snapshot_held_o), .protocol_error_o(protocol_error_o)
  );
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw_n, m2sel_n, m2b0;
    logic [5:0]  ctrl_n;
    logic [3:0]  dip_n;
  } pins_t;
  pins_t w_pins;
  assign w_pins = {apple_addr_i, apple_data_i, apple_rw_n_i, apple_m2sel_n_i, apple_m2b0_i,
                   apple_ctrl_n_i, dip_switches_n_i};
  pins_t hist [S];
  pins_t m_live, m_snap;
  logic [7:0] m_ctrl, m_dout;
  logic m_perr, m_held, m_valid = 1'b0;
  function automatic logic [7:0] rmap(pins_t s, logic [2:0] sel);
    case (sel)
      3'd0: return {1'b1, s.ctrl_n, s.rw_n};
      3'd1: return s.data;
      3'd2: return s.addr[7:0];
      3'd3: return s.addr[15:8];
      3'd4: return {6'b111111, s.m2sel_n, s.m2b0};
      3'd5: return {4'hF, s.dip_n};
      default: return 8'hFF;
    endcase
  endfunction
  always @(posedge clk_logic) begin
    if (reset) begin
      for (int i = 0; i < S; i++) hist[i] = '0;
      m_live = '0; m_snap = '0; m_ctrl = 8'hFF; m_dout = 8'h00;
      m_perr = 1'b0; m_held = 1'b0; m_valid = 1'b1;
    end else begin
      if (!m_held && !(!bridge_rd_n_i && (bridge_sel_i == 3'd1 || bridge_sel_i == 3'd2))) m_snap = m_live;
      if (!m_held) m_held = !bridge_rd_n_i && (bridge_sel_i == 3'd1 || bridge_sel_i == 3'd2);
      else m_held = !bridge_rd_n_i;
      m_live = '{addr: bridge_bus_a_oe_n_i ? m_live.addr : hist[S-1].addr, data: hist[S-1].data,
                 rw_n: hist[S-1].rw_n, m2sel_n: hist[S-1].m2sel_n, m2b0: hist[S-1].m2b0,
                 ctrl_n: hist[S-1].ctrl_n, dip_n: hist[S-1].dip_n};
      for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = w_pins;
      if (!bridge_wr_n_i && bridge_rd_n_i && bridge_sel_i == 3'd0) m_ctrl = bridge_d_i;
      if (!bridge_wr_n_i && bridge_rd_n_i && bridge_sel_i == 3'd1) m_dout = bridge_d_i;
      if (!bridge_wr_n_i && !bridge_rd_n_i) m_perr = 1'b1;
    end
  end
  task automatic chk(string n, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk_logic) begin
    if (m_valid && !reset) begin
      chk("m_d_o", {8'h0, bridge_d_o}, {8'h0, rmap(m_snap, bridge_sel_i)});
      chk("m_d_oe", {15'h0, bridge_d_oe_o}, {15'h0, !bridge_rd_n_i && bridge_wr_n_i});
      chk("m_inh", {15'h0, apple_inh_n_o}, {15'h0, m_ctrl[1]});
      chk("m_irq", {15'h0, apple_irq_n_o}, {15'h0, m_ctrl[2]});
      chk("m_data_o", {8'h0, apple_data_o}, {8'h0, m_dout});
      chk("m_data_oe", {15'h0, apple_data_oe_o}, {15'h0, !bridge_bus_d_oe_n_i});
      chk("m_held", {15'h0, snapshot_held_o}, {15'h0, m_held});
      chk("m_perr", {15'h0, protocol_error_o}, {15'h0, m_perr});
    end
  end
  task automatic tick(int n);
    repeat (n) @(posedge clk_logic);
    #2;
  endtask
  initial begin
    reset = 1'b1; bridge_sel_i = 3'd0; bridge_rd_n_i = 1'b1; bridge_wr_n_i = 1'b1;
    bridge_bus_a_oe_n_i = 1'b0; bridge_bus_d_oe_n_i = 1'b1; bridge_d_i = 8'h00;
    apple_addr_i = 16'h0000; apple_data_i = 8'h5A; apple_rw_n_i = 1'b1;
    apple_m2sel_n_i = 1'b1; apple_m2b0_i = 1'b0; apple_ctrl_n_i = 6'h3F; dip_switches_n_i = 4'hF;
    tick(3);
    reset = 1'b0; bridge_rd_n_i = 1'b0;
    @(negedge clk_logic);
    chk("rst_read", {8'h0, bridge_d_o}, 16'h0080);
    chk("rst_d_oe", {15'h0, bridge_d_oe_o}, 16'h1);
    chk("rst_irq_inh", {14'h0, apple_irq_n_o, apple_inh_n_o}, 16'h3);
    chk("rst_held_perr", {14'h0, snapshot_held_o, protocol_error_o}, 16'h0);
    tick(5);
    @(negedge clk_logic);
    chk("sel0_ff", {8'h0, bridge_d_o}, 16'h00FF);
    bridge_rd_n_i = 1'b1; apple_addr_i = 16'hC0E8;
    tick(5); bridge_rd_n_i = 1'b0; bridge_sel_i = 3'd2;
    @(negedge clk_logic);
    chk("addr_lo_e8", {8'h0, bridge_d_o}, 16'h00E8);
    tick(1); apple_addr_i = 16'h1234; bridge_sel_i = 3'd3;
    @(negedge clk_logic);
    chk("addr_hi_c0", {8'h0, bridge_d_o}, 16'h00C0);
    chk("held_up", {15'h0, snapshot_held_o}, 16'h1);
    tick(1); bridge_sel_i = 3'd0;
    @(negedge clk_logic);
    chk("frozen_rw", {8'h0, bridge_d_o}, 16'h00FF);
    tick(1); bridge_sel_i = 3'd4;
    @(negedge clk_logic);
    chk("frozen_m2", {8'h0, bridge_d_o}, 16'h00FE);
    tick(1); bridge_rd_n_i = 1'b1;
    @(negedge clk_logic);
    chk("held_lingers", {15'h0, snapshot_held_o}, 16'h1);
    tick(1);
    @(negedge clk_logic);
    chk("held_down", {15'h0, snapshot_held_o}, 16'h0);
    tick(4); bridge_rd_n_i = 1'b0; bridge_sel_i = 3'd2;
    @(negedge clk_logic);
    chk("addr_lo_34", {8'h0, bridge_d_o}, 16'h0034);
    tick(1); bridge_rd_n_i = 1'b1; bridge_bus_a_oe_n_i = 1'b1; apple_addr_i = 16'h5555;
    tick(6); bridge_rd_n_i = 1'b0; bridge_sel_i = 3'd3;
    @(negedge clk_logic);
    chk("addr_gated", {8'h0, bridge_d_o}, 16'h0012);
    tick(1); bridge_rd_n_i = 1'b1; bridge_bus_a_oe_n_i = 1'b0;
    tick(5); bridge_rd_n_i = 1'b0;
    @(negedge clk_logic);
    chk("addr_ungated", {8'h0, bridge_d_o}, 16'h0055);
    tick(1); bridge_rd_n_i = 1'b1; bridge_wr_n_i = 1'b0; bridge_sel_i = 3'd0; bridge_d_i = 8'hFB;
    @(negedge clk_logic);
    chk("irq_not_yet", {15'h0, apple_irq_n_o}, 16'h1);
    tick(1); bridge_wr_n_i = 1'b1;
    @(negedge clk_logic);
    chk("irq_low", {14'h0, apple_irq_n_o, apple_inh_n_o}, 16'h1);
    bridge_wr_n_i = 1'b0; bridge_d_i = 8'hFF;
    tick(1); bridge_wr_n_i = 1'b1;
    @(negedge clk_logic);
    chk("irq_inh_high", {14'h0, apple_irq_n_o, apple_inh_n_o}, 16'h3);
    bridge_wr_n_i = 1'b0; bridge_sel_i = 3'd1; bridge_d_i = 8'hA5; bridge_bus_d_oe_n_i = 1'b0;
    tick(1); bridge_wr_n_i = 1'b1;
    @(negedge clk_logic);
    chk("data_a5", {7'h0, apple_data_oe_o, apple_data_o}, 16'h01A5);
    bridge_bus_d_oe_n_i = 1'b1; #1;
    chk("data_oe_off", {15'h0, apple_data_oe_o}, 16'h0);
    bridge_rd_n_i = 1'b0; bridge_wr_n_i = 1'b0; bridge_sel_i = 3'd0; bridge_d_i = 8'h00;
    @(negedge clk_logic);
    chk("perr_d_oe", {15'h0, bridge_d_oe_o}, 16'h0);
    tick(1); bridge_rd_n_i = 1'b1; bridge_wr_n_i = 1'b1;
    @(negedge clk_logic);
    chk("perr_set", {13'h0, protocol_error_o, apple_irq_n_o, apple_inh_n_o}, 16'h7);
    tick(3);
    @(negedge clk_logic);
    chk("perr_sticky", {15'h0, protocol_error_o}, 16'h1);
    bridge_sel_i = 3'd1; bridge_wr_n_i = 1'b0; bridge_d_i = 8'h11;
    tick(1); bridge_d_i = 8'h22;
    tick(1); bridge_d_i = 8'h33;
    tick(1); bridge_sel_i = 3'd2; bridge_d_i = 8'h00;
    tick(1); bridge_wr_n_i = 1'b1;
    @(negedge clk_logic);
    chk("b2b_last_wins", {8'h0, apple_data_o}, 16'h0033);
    dip_switches_n_i = 4'b0111;
    tick(4); bridge_rd_n_i = 1'b0; bridge_sel_i = 3'd5;
    @(negedge clk_logic);
    chk("dip_f7", {8'h0, bridge_d_o}, 16'h00F7);
    tick(1); bridge_sel_i = 3'd6;
    @(negedge clk_logic);
    chk("sel6_ff", {8'h0, bridge_d_o}, 16'h00FF);
    tick(1); bridge_sel_i = 3'd7;
    @(negedge clk_logic);
    chk("sel7_ff", {8'h0, bridge_d_o}, 16'h00FF);
    tick(1); bridge_sel_i = 3'd1;
    tick(1);
    @(negedge clk_logic);
    chk("burst_held", {15'h0, snapshot_held_o}, 16'h1);
    reset = 1'b1; bridge_rd_n_i = 1'b1; bridge_wr_n_i = 1'b0; bridge_d_i = 8'h99;
    tick(1); reset = 1'b0; bridge_wr_n_i = 1'b1;
    @(negedge clk_logic);
    chk("midreset", {4'h0, apple_data_o, snapshot_held_o, protocol_error_o, apple_irq_n_o, apple_inh_n_o},
        16'h0003);
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
